// File: rtl/tx_axis_arbiter.sv
// Packet-granular round-robin arbiter: two AXI-Stream frame sources share one
// tx MAC input. Ownership is held from the first beat through tlast.
module tx_axis_arbiter #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int CNT_WIDTH   = 16,
   localparam int DATA_NBYTES = DATA_WIDTH/8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DATA_WIDTH-1:0]  s0_axis_tdata,
   input  logic [DATA_NBYTES-1:0] s0_axis_tkeep,
   input  logic                   s0_axis_tvalid,
   input  logic                   s0_axis_tlast,
   output logic                   s0_axis_tready,
   input  logic [DATA_WIDTH-1:0]  s1_axis_tdata,
   input  logic [DATA_NBYTES-1:0] s1_axis_tkeep,
   input  logic                   s1_axis_tvalid,
   input  logic                   s1_axis_tlast,
   output logic                   s1_axis_tready,
   output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
   output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
   output logic                   m00_axis_tvalid,
   output logic                   m00_axis_tlast,
   input  logic                   m00_axis_tready,
   output logic [1:0]             grant,
   output logic [CNT_WIDTH-1:0]   frame_count0,
   output logic [CNT_WIDTH-1:0]   frame_count1
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   eof0, eof1;

   // A frame ends on the accepted tlast beat of the owning port
   assign eof0 = (state == GRANT0) && s0_axis_tvalid && m00_axis_tready && s0_axis_tlast;
   assign eof1 = (state == GRANT1) && s1_axis_tvalid && m00_axis_tready && s1_axis_tlast;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         frame_count0 <= '0;
         frame_count1 <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == GRANT0) last_grant <= 1'b0;
         if (state == IDLE && state_nxt == GRANT1) last_grant <= 1'b1;
         if (eof0) frame_count0 <= frame_count0 + CNT_WIDTH'(1);
         if (eof1) frame_count1 <= frame_count1 + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (s0_axis_tvalid && s1_axis_tvalid)
               state_nxt = last_grant ? GRANT0 : GRANT1;
            else if (s0_axis_tvalid)
               state_nxt = GRANT0;
            else if (s1_axis_tvalid)
               state_nxt = GRANT1;
         end
         GRANT0:  if (eof0) state_nxt = IDLE;
         GRANT1:  if (eof1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant           = 2'b00;
      m00_axis_tdata  = '0;
      m00_axis_tkeep  = '0;
      m00_axis_tvalid = 1'b0;
      m00_axis_tlast  = 1'b0;
      s0_axis_tready  = 1'b0;
      s1_axis_tready  = 1'b0;
      case (state)
         GRANT0: begin
            grant           = 2'b01;
            m00_axis_tdata  = s0_axis_tdata;
            m00_axis_tkeep  = s0_axis_tkeep;
            m00_axis_tvalid = s0_axis_tvalid;
            m00_axis_tlast  = s0_axis_tlast;
            s0_axis_tready  = m00_axis_tready;
         end
         GRANT1: begin
            grant           = 2'b10;
            m00_axis_tdata  = s1_axis_tdata;
            m00_axis_tkeep  = s1_axis_tkeep;
            m00_axis_tvalid = s1_axis_tvalid;
            m00_axis_tlast  = s1_axis_tlast;
            s1_axis_tready  = m00_axis_tready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Bench for tx_axis_arbiter: a directed vector table plus streamed
// contention, backpressure and counter-wrap sequences.
module tb_tx_axis_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] s0_axis_tdata, s1_axis_tdata, m00_axis_tdata;
   logic [3:0]  s0_axis_tkeep, s1_axis_tkeep, m00_axis_tkeep;
   logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
   logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
   logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
   logic [1:0]  grant;
   logic [3:0]  frame_count0, frame_count1;

   int checks = 0;
   int fails  = 0;

   tx_axis_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
      .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
      .s0_axis_tready(s0_axis_tready),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
      .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
      .s1_axis_tready(s1_axis_tready),
      .m00_axis_tdata(m00_axis_tdata), .m00_axis_tkeep(m00_axis_tkeep),
      .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
      .m00_axis_tready(m00_axis_tready),
      .grant(grant), .frame_count0(frame_count0), .frame_count1(frame_count1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          v0, l0;
      logic [31:0] d0;
      logic [3:0]  k0;
      bit          v1, l1;
      logic [31:0] d1;
      logic [1:0]  g;
      bit          mv, ml, r0, r1;
      logic [31:0] md;
      logic [3:0]  mk;
      logic [3:0]  c0, c1;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic row(input bit rst, input bit v0, input logic [31:0] d0, input logic [3:0] k0,
                      input bit l0, input bit v1, input logic [31:0] d1, input bit l1,
                      input logic [1:0] g, input bit mv, input logic [31:0] md,
                      input logic [3:0] mk, input bit ml, input bit r0, input bit r1,
                      input logic [3:0] c0, input logic [3:0] c1);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.d0 = d0; v.k0 = k0; v.l0 = l0;
      v.v1 = v1; v.d1 = d1; v.l1 = l1; v.g = g; v.mv = mv; v.md = md;
      v.mk = mk; v.ml = ml; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
      s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
      m00_axis_tready = 1;
   endtask

   task automatic do_reset();
      reset_n = 0;
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   // Both sources stay valid whenever they have frames left, so the
   // expected output order is strict alternation starting with port 0.
   task automatic run_stream(input string nm, input int nf0, input int nf1,
                             input int len0, input int len1, input bit rnd);
      logic [32:0] q[$];
      logic [32:0] e;
      int f0 = 0, f1 = 0, b0 = 0, b1 = 0, cyc = 0, last_cyc = -1;
      bit exp_idle = 0;
      do_reset();
      while (f0 < nf0 || f1 < nf1) begin
         if (f0 < nf0) begin
            for (int b = 0; b < len0; b++) begin
               logic [31:0] w;
               w = {8'd0, f0[7:0], b[15:0]};
               q.push_back({(b == len0-1), w});
            end
            f0++;
         end
         if (f1 < nf1) begin
            for (int b = 0; b < len1; b++) begin
               logic [31:0] w;
               w = {8'd1, f1[7:0], b[15:0]};
               q.push_back({(b == len1-1), w});
            end
            f1++;
         end
      end
      f0 = 0; f1 = 0;
      while (q.size() > 0 && cyc < 400) begin
         s0_axis_tvalid = (f0 < nf0);
         s0_axis_tdata  = s0_axis_tvalid ? {8'd0, f0[7:0], b0[15:0]} : 32'd0;
         s0_axis_tkeep  = s0_axis_tvalid ? 4'hF : 4'h0;
         s0_axis_tlast  = s0_axis_tvalid && (b0 == len0-1);
         s1_axis_tvalid = (f1 < nf1);
         s1_axis_tdata  = s1_axis_tvalid ? {8'd1, f1[7:0], b1[15:0]} : 32'd0;
         s1_axis_tkeep  = s1_axis_tvalid ? 4'hF : 4'h0;
         s1_axis_tlast  = s1_axis_tvalid && (b1 == len1-1);
         m00_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #3;
         chk({nm, "_s0_tready"}, s0_axis_tready, (grant == 2'b01) ? m00_axis_tready : 1'b0);
         chk({nm, "_s1_tready"}, s1_axis_tready, (grant == 2'b10) ? m00_axis_tready : 1'b0);
         if (exp_idle) chk({nm, "_bubble_grant"}, grant, 2'b00);
         exp_idle = 0;
         if (m00_axis_tvalid && m00_axis_tready) begin
            e = q.pop_front();
            chk({nm, "_tdata"}, m00_axis_tdata, e[31:0]);
            chk({nm, "_tlast"}, m00_axis_tlast, e[32]);
            chk({nm, "_tkeep"}, m00_axis_tkeep, 4'hF);
            exp_idle = e[32];
            last_cyc = cyc;
         end
         if (s0_axis_tvalid && s0_axis_tready) begin
            if (s0_axis_tlast) begin f0++; b0 = 0; end else b0++;
         end
         if (s1_axis_tvalid && s1_axis_tready) begin
            if (s1_axis_tlast) begin f1++; b1 = 0; end else b1++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, "_beats_left"}, q.size(), 0);
      idle_inputs();
      #3;
      chk({nm, "_grant_end"}, grant, 2'b00);
      chk({nm, "_count0"}, frame_count0, 4'(nf0));
      chk({nm, "_count1"}, frame_count1, 4'(nf1));
      if (!rnd) chk({nm, "_last_cycle"}, last_cyc, nf0*(len0+1) + nf1*(len1+1) - 1);
      @(posedge clk); #1;
   endtask

   initial begin
      // rst, v0,d0,k0,l0, v1,d1,l1 | grant,mv,md,mk,ml,r0,r1,c0,c1
      row(1,1,32'hA0,4'hF,0, 0,0,0, 2'b00,0,0,0,0,0,0, 0,0);
      row(1,1,32'hA0,4'hF,0, 0,0,0, 2'b01,1,32'hA0,4'hF,0,1,0, 0,0);
      row(1,1,32'hA1,4'hF,0, 0,0,0, 2'b01,1,32'hA1,4'hF,0,1,0, 0,0);
      row(1,1,32'hA2,4'hF,0, 0,0,0, 2'b01,1,32'hA2,4'hF,0,1,0, 0,0);
      row(1,1,32'hA3,4'h3,1, 0,0,0, 2'b01,1,32'hA3,4'h3,1,1,0, 0,0);
      row(1,0,0,0,0,         0,0,0, 2'b00,0,0,0,0,0,0, 1,0);
      // port 0 stalls mid-frame while port 1 waits
      row(1,1,32'hB0,4'hF,0, 0,0,0,        2'b00,0,0,0,0,0,0, 1,0);
      row(1,1,32'hB0,4'hF,0, 1,32'hC0,1,   2'b01,1,32'hB0,4'hF,0,1,0, 1,0);
      row(1,1,32'hB1,4'hF,0, 1,32'hC0,1,   2'b01,1,32'hB1,4'hF,0,1,0, 1,0);
      row(1,0,0,0,0,         1,32'hC0,1,   2'b01,0,0,0,0,1,0, 1,0);
      row(1,0,0,0,0,         1,32'hC0,1,   2'b01,0,0,0,0,1,0, 1,0);
      row(1,0,0,0,0,         1,32'hC0,1,   2'b01,0,0,0,0,1,0, 1,0);
      row(1,1,32'hB2,4'hF,0, 1,32'hC0,1,   2'b01,1,32'hB2,4'hF,0,1,0, 1,0);
      row(1,1,32'hB3,4'hF,1, 1,32'hC0,1,   2'b01,1,32'hB3,4'hF,1,1,0, 1,0);
      row(1,0,0,0,0,         1,32'hC0,1,   2'b00,0,0,0,0,0,0, 2,0);
      row(1,0,0,0,0,         1,32'hC0,1,   2'b10,1,32'hC0,4'hF,1,0,1, 2,0);
      row(1,0,0,0,0,         0,0,0,        2'b00,0,0,0,0,0,0, 2,1);
      // reset lands on beat 2 of a port-0 frame
      row(1,1,32'hD0,4'hF,0, 0,0,0,        2'b00,0,0,0,0,0,0, 2,1);
      row(1,1,32'hD0,4'hF,0, 0,0,0,        2'b01,1,32'hD0,4'hF,0,1,0, 2,1);
      row(0,1,32'hD1,4'hF,0, 0,0,0,        2'b01,1,32'hD1,4'hF,0,1,0, 2,1);
      row(1,1,32'hD2,4'hF,0, 1,32'hE0,1,   2'b00,0,0,0,0,0,0, 0,0);
      row(1,1,32'hD2,4'hF,0, 1,32'hE0,1,   2'b01,1,32'hD2,4'hF,0,1,0, 0,0);

      do_reset();
      foreach (tbl[i]) begin
         reset_n         = tbl[i].rst;
         s0_axis_tvalid  = tbl[i].v0;
         s0_axis_tdata   = tbl[i].d0;
         s0_axis_tkeep   = tbl[i].k0;
         s0_axis_tlast   = tbl[i].l0;
         s1_axis_tvalid  = tbl[i].v1;
         s1_axis_tdata   = tbl[i].d1;
         s1_axis_tkeep   = tbl[i].v1 ? 4'hF : 4'h0;
         s1_axis_tlast   = tbl[i].l1;
         m00_axis_tready = 1'b1;
         #3;
         chk($sformatf("row%0d_grant", i),  grant,           tbl[i].g);
         chk($sformatf("row%0d_tvalid", i), m00_axis_tvalid, tbl[i].mv);
         chk($sformatf("row%0d_tdata", i),  m00_axis_tdata,  tbl[i].md);
         chk($sformatf("row%0d_tkeep", i),  m00_axis_tkeep,  tbl[i].mk);
         chk($sformatf("row%0d_tlast", i),  m00_axis_tlast,  tbl[i].ml);
         chk($sformatf("row%0d_s0rdy", i),  s0_axis_tready,  tbl[i].r0);
         chk($sformatf("row%0d_s1rdy", i),  s1_axis_tready,  tbl[i].r1);
         chk($sformatf("row%0d_cnt0", i),   frame_count0,    tbl[i].c0);
         chk($sformatf("row%0d_cnt1", i),   frame_count1,    tbl[i].c1);
         @(posedge clk); #1;
      end

      run_stream("contention",   4, 4,  3, 3, 1'b0);
      run_stream("backpressure", 0, 1,  1, 6, 1'b1);
      run_stream("wrap_single",  0, 17, 1, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
